// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register stage with valid/ready handshaking,
// flush (squash) and a saturating stall counter.
//
// Build option: define PIPE_STAGE_REG_SKID_EN to add a one-entry skid
// register. in_ready then comes from a flop and has no combinational path
// from out_ready, and the stage holds two entries. Without the macro the
// stage holds one entry and in_ready = out_ready | ~out_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (priority over everything)
//   flush      drops held and incoming entries; out_data keeps its value
//   in_valid   upstream entry present
//   in_ready   stage accepts an entry this cycle
//   in_data    upstream payload (DATA_W)
//   out_valid  downstream entry present (flop)
//   out_ready  downstream accepts this cycle
//   out_data   payload (flop)
//   stall_cnt  saturating count of cycles with out_valid & ~out_ready (flop)
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              in_xfer;
    logic              stall;
    logic              main_valid_nxt;
    logic [DATA_W-1:0] main_data_nxt;
    logic [CNT_W-1:0]  stall_cnt_nxt;

    assign in_xfer = in_valid & in_ready;
    assign stall   = out_valid & ~out_ready;

    // Stall counter: counts held-but-not-taken cycles, saturates, ignores flush
    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (!flush && stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt_nxt = stall_cnt + CNT_W'(1);
        end
    end

`ifdef PIPE_STAGE_REG_SKID_EN
    logic              skid_valid;
    logic              skid_valid_nxt;
    logic [DATA_W-1:0] skid_data;
    logic [DATA_W-1:0] skid_data_nxt;

    // Ready depends only on the skid flop, breaking the out_ready path
    assign in_ready = ~skid_valid;

    // Main/skid next state; skid only fills while main is stalled
    always_comb begin
        main_valid_nxt = out_valid;
        main_data_nxt  = out_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (!out_valid) begin
            if (in_xfer) begin
                main_valid_nxt = 1'b1;
                main_data_nxt  = in_data;
            end
        end else if (out_ready) begin
            // Older skid entry goes first; in_ready was low if skid was full
            if (skid_valid) begin
                main_data_nxt  = skid_data;
                skid_valid_nxt = 1'b0;
            end else if (in_xfer) begin
                main_data_nxt  = in_data;
            end else begin
                main_valid_nxt = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_nxt = 1'b1;
            skid_data_nxt  = in_data;
        end
    end

    // Skid register
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
        end
    end
`else
    logic out_xfer;

    assign out_xfer = out_valid & out_ready;
    // Slot is free when empty or being drained this cycle
    assign in_ready = out_ready | ~out_valid;

    // Single-slot next state
    always_comb begin
        main_valid_nxt = out_valid;
        main_data_nxt  = out_data;
        if (flush) begin
            main_valid_nxt = 1'b0;
        end else if (in_xfer) begin
            main_valid_nxt = 1'b1;
            main_data_nxt  = in_data;
        end else if (out_xfer) begin
            main_valid_nxt = 1'b0;
        end
    end
`endif

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            stall_cnt <= '0;
        end else begin
            out_valid <= main_valid_nxt;
            out_data  <= main_data_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a scoreboard of accepted entries.
// Two instances share stimulus: default CNT_W and CNT_W=4 for saturation.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 32;
`ifdef PIPE_STAGE_REG_SKID_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;

    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cnt;

    logic          in_ready_s;
    logic          out_valid_s;
    logic [DW-1:0] out_data_s;
    logic [3:0]    stall_cnt_s;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sb[$];   // accepted, not yet delivered (front = on output)
    logic [DW-1:0] src[$];  // upstream entries waiting to be offered
    int unsigned   cnt16 = 0;
    int unsigned   cnt4  = 0;

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .stall_cnt(stall_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check before the rising edge, advance model
    task automatic step(input bit ordy, input bit fl, input bit rs);
        bit exp_rdy;
        bit acc;
        bit outx;
        @(negedge clk);
        rst       = rs;
        flush     = fl;
        out_ready = ordy;
        in_valid  = (src.size() > 0);
        in_data   = (src.size() > 0) ? src[0] : '0;
        #1;
        if (CAP == 2) exp_rdy = (sb.size() < 2);
        else          exp_rdy = (sb.size() == 0) || ordy;
        chk("in_ready",    64'(in_ready),    64'(exp_rdy));
        chk("in_ready_s",  64'(in_ready_s),  64'(exp_rdy));
        chk("out_valid",   64'(out_valid),   64'(sb.size() > 0));
        chk("out_valid_s", 64'(out_valid_s), 64'(sb.size() > 0));
        if (sb.size() > 0) begin
            chk("out_data",   64'(out_data),   64'(sb[0]));
            chk("out_data_s", 64'(out_data_s), 64'(sb[0]));
        end
        chk("stall_cnt",   64'(stall_cnt),   64'(cnt16));
        chk("stall_cnt_s", 64'(stall_cnt_s), 64'(cnt4));
        if (rs) begin
            sb.delete();
            cnt16 = 0;
            cnt4  = 0;
        end else if (fl) begin
            sb.delete();
            if (src.size() > 0) void'(src.pop_front());
        end else begin
            acc  = in_valid && exp_rdy;
            outx = (sb.size() > 0) && ordy;
            if ((sb.size() > 0) && !ordy) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15)     cnt4++;
            end
            if (outx) void'(sb.pop_front());
            if (acc)  sb.push_back(src.pop_front());
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset held two cycles, then released
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);

        // Streaming, one transfer per cycle
        src.push_back(32'h10); src.push_back(32'h11); src.push_back(32'h12);
        for (int i = 0; i < 5; i++) step(1, 0, 0);

        // Backpressure, then drain in order
        src.push_back(32'hA0); src.push_back(32'hA1); src.push_back(32'hA2);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd3);
        chk("bp_in_ready",  64'(in_ready),  64'h0);
        chk("bp_out_data",  64'(out_data),  64'hA0);
        for (int i = 0; i < 6; i++) step(1, 0, 0);

        // Flush with a simultaneous incoming entry
        src.push_back(32'hB0); src.push_back(32'hB1);
        step(0, 0, 0);
        step(0, 0, 0);
        src.delete();
        src.push_back(32'hB2);
        step(0, 1, 0);
        step(1, 0, 0);
        chk("flush_out_data_hold", 64'(out_data),  64'hB0);
        chk("flush_out_valid",     64'(out_valid), 64'h0);
        step(1, 0, 0);
        step(1, 0, 0);

        // Saturation of the 4-bit counter
        step(0, 0, 1);
        src.push_back(32'hC0);
        for (int i = 0; i < 22; i++) step(0, 0, 0);
        chk("sat_hold_15", 64'(stall_cnt_s), 64'd15);
        step(1, 0, 0);
        step(1, 0, 0);

        // Reset while full and stalled
        src.push_back(32'hD0); src.push_back(32'hD1); src.push_back(32'hD2);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("midrst_out_valid", 64'(out_valid), 64'h0);
        chk("midrst_out_data",  64'(out_data),  64'h0);
        chk("midrst_in_ready",  64'(in_ready),  64'h1);
        chk("midrst_stall_cnt", 64'(stall_cnt), 64'h0);
        for (int i = 0; i < 6; i++) step(1, 0, 0);

        // Random traffic with occasional flush
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) src.push_back($urandom);
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 0);
        end
        for (int i = 0; i < 80 && (src.size() > 0 || sb.size() > 0); i++) step(1, 0, 0);
        step(1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning payload width in bits (packed pipeline fields: bus A/B, pc, imm, op, funct3, rd).
REQ-002 SHALL provide parameter CNT_W, default 16, meaning width of the saturating stall counter.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL provide port flush, input, 1, discards all held and incoming entries (branch/jump squash).
REQ-006 SHALL provide port in_valid, input, 1, upstream entry present.
REQ-007 SHALL provide port in_ready, output, 1, stage accepts an entry this cycle.
REQ-008 SHALL provide port in_data, input, DATA_W, upstream payload.
REQ-009 SHALL provide port out_valid, output, 1, downstream entry present.
REQ-010 SHALL provide port out_ready, input, 1, downstream accepts this cycle.
REQ-011 SHALL provide port out_data, output, DATA_W, registered payload.
REQ-012 SHALL provide port stall_cnt, output, CNT_W, count of cycles with out_valid=1 and out_ready=0.

Function
REQ-013 SHALL accept an entry when in_valid=1 and in_ready=1 at a rising edge (input transfer), and deliver one when out_valid=1 and out_ready=1 (output transfer).
REQ-014 SHALL drive out_valid, out_data and stall_cnt only from registers; out_data SHALL be a direct flop output.
REQ-015 SHALL give one-cycle latency: an entry accepted at edge N with the stage empty appears on out_data/out_valid after edge N.
REQ-016 SHALL sustain one transfer per cycle while in_valid=1 and out_ready=1 continuously.
REQ-017 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL never drop, duplicate or reorder an accepted entry except under flush or rst.
REQ-019 SHALL, when flush=1 at an edge, clear all entry valid bits, ignore in_valid that cycle and leave out_data unchanged; flush overrides simultaneous input and output transfers.
REQ-020 SHALL increment stall_cnt each cycle where out_valid=1 and out_ready=0 and flush=0, saturating at 2^CNT_W-1 without wrapping.
REQ-021 SHALL leave stall_cnt unaffected by flush.

Reset
REQ-022 SHALL, when rst=1 at an edge, clear out_valid, all internal valid bits, out_data, skid data and stall_cnt to 0; rst has priority over flush and all transfers.
REQ-023 SHALL drive in_ready=1 on the first cycle after reset is released, mid-operation included; entries held at reset are lost.

Configuration
REQ-024 SHALL use macro PIPE_STAGE_REG_SKID_EN to select the ready-path structure.
REQ-025 SHALL, with PIPE_STAGE_REG_SKID_EN defined, include a one-entry skid register: in_ready = NOT skid_valid, registered with no combinational path from out_ready; an entry accepted while out_valid=1 and out_ready=0 goes to skid; on the next output transfer main takes skid data if skid_valid, else in_data.
REQ-026 SHALL, without PIPE_STAGE_REG_SKID_EN, omit skid storage and drive in_ready = out_ready OR NOT out_valid combinationally; capacity is one entry.
REQ-027 SHALL keep REQ-013..REQ-023 identical in both builds apart from in_ready timing and capacity (2 entries with skid, 1 without).

Verification
REQ-028 SHALL cover reset: rst=1 two cycles, then release -> out_valid=0, out_data=0, stall_cnt=0, in_ready=1.
REQ-029 SHALL cover streaming: in_data=0x10,0x11,0x12 on consecutive cycles, out_ready=1 -> out_data 0x10,0x11,0x12 one cycle later each, out_valid high 3 cycles.
REQ-030 SHALL cover backpressure: send 0xA0,0xA1,0xA2 with out_ready=0 for 3 cycles -> skid build: 0xA0 on output, 0xA1 in skid, in_ready=0, 0xA2 held upstream; stall_cnt=3; then out_ready=1 -> 0xA0,0xA1,0xA2 in order; non-skid build: in_ready=0 after 0xA0.
REQ-031 SHALL cover flush with simultaneous input: stage holds 0xB0 (plus 0xB1 in skid), flush=1 with in_valid=1 in_data=0xB2 -> next cycle out_valid=0, 0xB2 never delivered, stall_cnt unchanged.
REQ-032 SHALL cover saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds 15.
REQ-033 SHALL cover reset mid-operation: rst=1 while stage full and stalled -> next cycle out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
